// File: rtl/calc_entry_ctrl_pkg.sv
// Shared definitions for the calculator entry controller: key codes, FSM
// encoding, demux select codes and key classification helpers.
package calc_pkg;

    localparam logic [3:0] KEY_ADD = 4'hA;
    localparam logic [3:0] KEY_SUB = 4'hB;
    localparam logic [3:0] KEY_AND = 4'hC;
    localparam logic [3:0] KEY_OR  = 4'hD;
    localparam logic [3:0] KEY_EQ  = 4'hE;
    localparam logic [3:0] KEY_CLR = 4'hF;

    localparam logic [1:0] SEL_V1   = 2'b00;
    localparam logic [1:0] SEL_OP   = 2'b01;
    localparam logic [1:0] SEL_V2   = 2'b10;
    localparam logic [1:0] SEL_DISP = 2'b11;

    typedef enum logic [2:0] {
        GET_V1  = 3'd0,
        GET_OP  = 3'd1,
        GET_V2  = 3'd2,
        WAIT_EQ = 3'd3,
        EXEC    = 3'd4,
        SHOW    = 3'd5
    } fsm_t;

    function automatic logic is_digit(input logic [3:0] key);
        return key <= 4'd9;
    endfunction

    function automatic logic is_op(input logic [3:0] key);
        return (key >= KEY_ADD) && (key <= KEY_OR);
    endfunction

    function automatic logic [1:0] sel_of(input fsm_t s);
        case (s)
            GET_V1:          return SEL_V1;
            GET_OP:          return SEL_OP;
            GET_V2, WAIT_EQ: return SEL_V2;
            default:         return SEL_DISP;
        endcase
    endfunction

endpackage

// File: rtl/calc_entry_ctrl_if.sv
// Keypad-in / ULA-and-display-out bundle of the entry controller.
interface calc_entry_ctrl_if;

    logic       key_valid;
    logic [3:0] keyboard;
    logic       alu_done;
    logic [3:0] alu_result;
    logic [1:0] state;
    logic [3:0] OutV1;
    logic [3:0] OutOP;
    logic [3:0] OutV2;
    logic       alu_start;
    logic [3:0] result;
    logic       result_valid;
    logic       err;

    modport master (
        output key_valid, keyboard, alu_done, alu_result,
        input  state, OutV1, OutOP, OutV2, alu_start, result, result_valid, err
    );

    modport slave (
        input  key_valid, keyboard, alu_done, alu_result,
        output state, OutV1, OutOP, OutV2, alu_start, result, result_valid, err
    );

endinterface

// File: rtl/calc_entry_ctrl_watchdog.sv
// Loadable 4-bit down-counter guarding the wait for the ULA result.
// expired is high during the last counted cycle, so a load of N fires N cycles after the load edge.
module calc_watchdog (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       clear,
    input  logic [3:0] load_value,
    output logic       expired
);

    logic [3:0] count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= 4'd0;
        end else if (clear) begin
            count <= 4'd0;
        end else if (start) begin
            count <= load_value;
        end else if (count != 4'd0) begin
            count <= count - 4'd1;
        end
    end

    assign expired = (count == 4'd1);

endmodule

// File: rtl/calc_entry_ctrl.sv
// Calculator entry sequencer: walks V1 -> OP -> V2 -> '=', launches the ULA
// and holds its result for display.
module calc_entry_ctrl
    import calc_pkg::*;
#(
    parameter int unsigned TIMEOUT = 15
) (
    input logic              clk,
    input logic              rst_n,
    calc_entry_ctrl_if.slave bus
);

    localparam logic [3:0] TIMEOUT_LOAD = 4'(TIMEOUT);

    fsm_t       fsm;
    fsm_t       fsm_next;
    logic [3:0] v1_q, v1_d;
    logic [3:0] op_q, op_d;
    logic [3:0] v2_q, v2_d;
    logic [3:0] res_q, res_d;
    logic       rv_q, rv_d;
    logic       start_q, start_d;
    logic       err_q, err_d;
    logic       wd_start, wd_clear, wd_expired;

    logic key_clr, key_dig, key_op, key_eq, key_any;

    assign key_clr = bus.key_valid && (bus.keyboard == KEY_CLR);
    assign key_eq  = bus.key_valid && (bus.keyboard == KEY_EQ);
    assign key_dig = bus.key_valid && is_digit(bus.keyboard);
    assign key_op  = bus.key_valid && is_op(bus.keyboard);
    assign key_any = bus.key_valid && !key_clr;

    calc_watchdog u_watchdog (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (wd_start),
        .clear      (wd_clear),
        .load_value (TIMEOUT_LOAD),
        .expired    (wd_expired)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fsm <= GET_V1;
        end else begin
            fsm <= fsm_next;
        end
    end

    // Clear wins over every other event, including a same-cycle alu_done.
    always_comb begin
        fsm_next = fsm;
        if (key_clr) begin
            fsm_next = GET_V1;
        end else begin
            case (fsm)
                GET_V1:  if (key_dig) fsm_next = GET_OP;
                GET_OP:  if (key_op)  fsm_next = GET_V2;
                GET_V2:  if (key_dig) fsm_next = WAIT_EQ;
                WAIT_EQ: if (key_eq)  fsm_next = EXEC;
                EXEC: begin
                    if (bus.alu_done)     fsm_next = SHOW;
                    else if (wd_expired)  fsm_next = GET_V1;
                end
                SHOW: begin
                    if (key_dig)          fsm_next = GET_OP;
                    else if (key_op)      fsm_next = GET_V2;
                end
                default:                  fsm_next = GET_V1;
            endcase
        end
    end

    always_comb begin
        v1_d     = v1_q;
        op_d     = op_q;
        v2_d     = v2_q;
        res_d    = res_q;
        rv_d     = rv_q;
        start_d  = 1'b0;
        err_d    = 1'b0;
        wd_start = 1'b0;
        wd_clear = 1'b0;
        if (key_clr) begin
            v1_d     = 4'd0;
            op_d     = 4'd0;
            v2_d     = 4'd0;
            res_d    = 4'd0;
            rv_d     = 1'b0;
            wd_clear = 1'b1;
        end else begin
            case (fsm)
                GET_V1: begin
                    if (key_dig)      v1_d  = bus.keyboard;
                    else if (key_any) err_d = 1'b1;
                end
                GET_OP: begin
                    if (key_op)       op_d  = bus.keyboard;
                    else if (key_dig) v1_d  = bus.keyboard;
                    else if (key_eq)  err_d = 1'b1;
                end
                GET_V2: begin
                    if (key_dig)      v2_d  = bus.keyboard;
                    else if (key_any) err_d = 1'b1;
                end
                WAIT_EQ: begin
                    if (key_eq) begin
                        start_d  = 1'b1;
                        wd_start = 1'b1;
                    end else if (key_dig) begin
                        v2_d = bus.keyboard;
                    end else if (key_op) begin
                        err_d = 1'b1;
                    end
                end
                EXEC: begin
                    if (bus.alu_done) begin
                        res_d    = bus.alu_result;
                        rv_d     = 1'b1;
                        wd_clear = 1'b1;
                    end else if (wd_expired) begin
                        err_d    = 1'b1;
                        rv_d     = 1'b0;
                        wd_clear = 1'b1;
                    end
                end
                SHOW: begin
                    if (key_dig) begin
                        v1_d = bus.keyboard;
                        rv_d = 1'b0;
                    end else if (key_op) begin
                        v1_d = res_q;
                        op_d = bus.keyboard;
                        rv_d = 1'b0;
                    end else if (key_eq) begin
                        err_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1_q    <= 4'd0;
            op_q    <= 4'd0;
            v2_q    <= 4'd0;
            res_q   <= 4'd0;
            rv_q    <= 1'b0;
            start_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            v1_q    <= v1_d;
            op_q    <= op_d;
            v2_q    <= v2_d;
            res_q   <= res_d;
            rv_q    <= rv_d;
            start_q <= start_d;
            err_q   <= err_d;
        end
    end

    assign bus.state        = sel_of(fsm);
    assign bus.OutV1        = v1_q;
    assign bus.OutOP        = op_q;
    assign bus.OutV2        = v2_q;
    assign bus.result       = res_q;
    assign bus.result_valid = rv_q;
    assign bus.alu_start    = start_q;
    assign bus.err          = err_q;

endmodule
